// File: rtl/chunk_serial_adder_if.sv
// -----------------------------------------------------------------------------
// chunk_serial_adder_if
//
// Operand/result handshake bundle for chunk_serial_adder.
//
// Signals (directions given for the slave, i.e. the adder):
//   in_valid  in   operands a, b, cin are valid
//   in_ready  out  adder can accept operands
//   a, b      in   operands, WIDTH bits
//   cin       in   carry-in
//   sub       in   subtract request (only with CHUNK_SERIAL_ADDER_SUB_EN)
//   sum       out  result, WIDTH bits
//   carry_out out  carry out of bit WIDTH-1 (no-borrow flag when subtracting)
//   out_valid out  sum/carry_out valid
//   out_ready in   consumer accepts result
//   busy      out  adder is stepping through chunks
//
// Optional feature macro: CHUNK_SERIAL_ADDER_SUB_EN adds the sub signal.
// -----------------------------------------------------------------------------
interface chunk_serial_adder_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

`ifdef CHUNK_SERIAL_ADDER_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, sum, carry_out, out_valid, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, sum, carry_out, out_valid, busy
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, sum, carry_out, out_valid, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, sum, carry_out, out_valid, busy
  );
`endif

endinterface : chunk_serial_adder_if

// File: rtl/chunk_serial_adder.sv
// -----------------------------------------------------------------------------
// chunk_serial_adder
//
// Adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock cycle,
// least significant chunk first. A result takes WIDTH/CHUNK cycles from the
// accept edge; it is then held with out_valid until the consumer takes it.
//
// Parameters:
//   WIDTH  operand/result width in bits
//   CHUNK  bits added per cycle; WIDTH must be a multiple of CHUNK
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   bus    chunk_serial_adder_if.slave: in_valid/in_ready operand handshake
//          (a, b, cin), out_valid/out_ready result handshake (sum,
//          carry_out), busy status
//
// Optional feature macro: CHUNK_SERIAL_ADDER_SUB_EN
//   When defined, bus.sub is sampled with the operands. sub=1 computes a-b by
//   adding ~b with a forced carry-in of 1 (cin ignored); carry_out=1 then
//   means no borrow. Without the macro the block only adds.
//
// Flow: IDLE (in_ready=1) -> RUN (busy=1, WIDTH/CHUNK cycles) -> DONE
// (out_valid=1) -> IDLE on out_ready. Accept and handoff never share a cycle,
// so the shortest issue interval is WIDTH/CHUNK+2 cycles.
// -----------------------------------------------------------------------------
module chunk_serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  chunk_serial_adder_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // Keep the index at least one bit wide when the whole word is one chunk.
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  // Elaboration-time parameter sanity.
  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("chunk_serial_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  if ($bits(bus.a) != WIDTH) begin : g_bad_if_width
    $error("chunk_serial_adder: interface width %0d differs from WIDTH %0d",
           $bits(bus.a), WIDTH);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;          // chunk currently being added
  logic             carry_q;      // carry into the current chunk
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;          // already inverted for subtraction
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             busy_q;

  logic             sub_req;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_res;    // {chunk carry-out, chunk sum}

`ifdef CHUNK_SERIAL_ADDER_SUB_EN
  assign sub_req = bus.sub;
`else
  assign sub_req = 1'b0;
`endif

  // One CHUNK-bit ripple slice; the carry between slices lives in carry_q.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first) so no latch is inferred.
  always_comb begin
    a_chunk   = '0;
    b_chunk   = '0;
    a_chunk   = a_q[idx*CHUNK +: CHUNK];
    b_chunk   = b_q[idx*CHUNK +: CHUNK];
    chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_q);
  end

  // Single-process FSM; all outputs are registered alongside the state.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the operand and result registers are reset too: reset must clear
  // sum/carry_out immediately, and clean operand registers keep simulation
  // free of X on the chunk datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            // Subtraction is a + ~b + 1; cin is ignored in that mode.
            b_q        <= sub_req ? ~bus.b : bus.b;
            carry_q    <= sub_req ? 1'b1 : bus.cin;
            idx        <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        RUN: begin
          sum_q[idx*CHUNK +: CHUNK] <= chunk_res[CHUNK-1:0];
          carry_q                   <= chunk_res[CHUNK];
          if (idx == LAST_IDX) begin
            carry_out_q <= chunk_res[CHUNK];
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            idx         <= '0;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          // Result is frozen here; in_valid is ignored until back in IDLE.
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          idx         <= '0;
          carry_q     <= 1'b0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule : chunk_serial_adder
